// File: rtl/division_punto_fijo_pkg.sv
// Shared constants and FSM state type for the sign-magnitude fixed-point divider.
package division_punto_fijo_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 16;
  localparam int ITER_DEF  = WIDTH_DEF - 1 + FRAC_DEF;

  // One quotient bit per magnitude bit of the pre-shifted dividend.
  function automatic int iter_count(input int width, input int frac);
    return width - 1 + frac;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/division_paso.sv
// One combinational radix-2 restoring division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module division_paso #(
  parameter int MAG = 31
) (
  input  logic [MAG-1:0] rem,
  input  logic           bit_in,
  input  logic [MAG-1:0] divisor,
  output logic [MAG-1:0] rem_next,
  output logic           q_bit
);

  logic [MAG:0]   shifted;
  logic [MAG+1:0] trial;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted  = {rem, bit_in};
    trial    = {1'b0, shifted} - {2'b00, divisor};
    q_bit    = ~trial[MAG+1];
    rem_next = q_bit ? trial[MAG-1:0] : shifted[MAG-1:0];
  end

endmodule

// File: rtl/division_punto_fijo.sv
// Sequential sign-magnitude fixed-point divider: fixed latency, saturates on
// overflow and on a zero divisor.
module division_punto_fijo
  import division_punto_fijo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic             ovf
);

  localparam int MAG  = WIDTH - 1;
  localparam int ITER = iter_count(WIDTH, FRAC);
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER);

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [ITER-1:0] dividend, quot;
  logic [MAG-1:0]  b_mag, rem, rem_next;
  logic            a_sign, b_sign, q_bit;
  logic [MAG-1:0]  s_mag;
  logic            b_zero, q_ovf, s_sign;

  division_paso #(.MAG(MAG)) u_paso (
    .rem      (rem),
    .bit_in   (dividend[ITER-1]),
    .divisor  (b_mag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A zero-magnitude divisor is treated as +0, so only A's sign survives.
  always_comb begin
    b_zero = (b_mag == '0);
    q_ovf  = |quot[ITER-1:MAG];
    s_mag  = (b_zero || q_ovf) ? '1 : quot[MAG-1:0];
    s_sign = b_zero ? a_sign : ((a_sign ^ b_sign) && (s_mag != '0));
  end

  // NOTE: every datapath register is reset so an aborted operation leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      dividend <= '0;
      quot     <= '0;
      rem      <= '0;
      b_mag    <= '0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      S        <= '0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_sign   <= A[WIDTH-1];
          b_sign   <= B[WIDTH-1];
          b_mag    <= B[MAG-1:0];
          dividend <= {A[MAG-1:0], {FRAC{1'b0}}};
          rem      <= '0;
          quot     <= '0;
          cnt      <= '0;
        end
        CALC: if (cnt != LAST) begin
          rem      <= rem_next;
          quot     <= {quot[ITER-2:0], q_bit};
          dividend <= {dividend[ITER-2:0], 1'b0};
          cnt      <= cnt + 1'b1;
        end else begin
          // Final CALC cycle: all quotient bits are in, register the result.
          S    <= {s_sign, s_mag};
          div0 <= b_zero;
          ovf  <= q_ovf && !b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division_punto_fijo.sv
// Randomised self-checking bench for division_punto_fijo against a plain
// arithmetic model of the quotient, saturation, sign and fixed latency.
module tb_division_punto_fijo;

  localparam int LAT = 48;

  typedef struct {
    logic [31:0] s;
    logic        d0;
    logic        ov;
    int          cyc;
  } exp_t;

  logic        clk, rst, start;
  logic [31:0] A, B, S;
  logic        busy, done, div0, ovf;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int busy_until = -1;
  exp_t q[$];
  logic [31:0] last_s;
  logic        last_d0, last_ov;

  division_punto_fijo #(.WIDTH(32), .FRAC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .S(S), .busy(busy), .done(done), .div0(div0), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint unsigned am, bm, qt;
    logic [30:0] mag;
    logic sg;
    am = 64'(a[30:0]);
    bm = 64'(b[30:0]);
    r.d0 = 1'b0;
    r.ov = 1'b0;
    r.cyc = 0;
    if (bm == 0) begin
      r.d0 = 1'b1;
      r.s  = {a[31], 31'h7FFF_FFFF};
    end else begin
      qt = (am << 16) / bm;
      if (qt > 64'h7FFF_FFFF) begin
        r.ov = 1'b1;
        mag  = 31'h7FFF_FFFF;
      end else begin
        mag = qt[30:0];
      end
      sg = (a[31] ^ b[31]) && (mag != 0);
      r.s = {sg, mag};
    end
    return r;
  endfunction

  // Model update on the rising edge, comparison on the falling edge.
  initial begin
    exp_t e;
    last_s = '0; last_d0 = 1'b0; last_ov = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst && start && cycle > busy_until) begin
        e = model(A, B);
        e.cyc = cycle + 1 + LAT;
        busy_until = e.cyc;
        q.push_back(e);
      end
      cycle++;
      @(negedge clk);
      if (rst) begin
        check("reset_outputs", {S, busy, done, div0, ovf}, 64'd0);
        q.delete();
        busy_until = -1;
        last_s = '0; last_d0 = 1'b0; last_ov = 1'b0;
      end else begin
        check("busy_done_exclusive", busy && done, 1'b0);
        check("busy", busy, (q.size() > 0) && (cycle < q[0].cyc));
        if (q.size() > 0 && cycle == q[0].cyc) begin
          e = q.pop_front();
          check("done_pulse", done, 1'b1);
          check("result", {S, div0, ovf}, {e.s, e.d0, e.ov});
          last_s = e.s; last_d0 = e.d0; last_ov = e.ov;
        end else begin
          check("no_done", done, 1'b0);
          check("hold", {S, div0, ovf}, {last_s, last_d0, last_ov});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s_req, input logic d0_req, input logic ov_req);
    int i;
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom;
    i = 0;
    while (!done && i < 60) begin
      tick();
      i++;
    end
    check({name, "_latency"}, i, LAT);
    check({name, "_S"}, S, s_req);
    check({name, "_flags"}, {div0, ovf}, {d0_req, ov_req});
    tick();
  endtask

  function automatic logic [31:0] rand_b(input int mode);
    logic [31:0] b;
    b = $urandom;
    case (mode)
      1: b = b & 32'h8003_FFFF;
      2: b = b & 32'h8000_0000;
      default: ;
    endcase
    return b;
  endfunction

  initial begin
    exp_t m;
    int prev, mode;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    m = model(32'h0004_E000, 32'h0001_8000);
    check("model_4p875_div_1p5", {m.s, m.d0, m.ov}, {32'h0003_4000, 1'b0, 1'b0});
    m = model(32'h0001_0000, 32'h0003_0000);
    check("model_one_third", {m.s, m.d0, m.ov}, {32'h0000_5555, 1'b0, 1'b0});
    m = model(32'h0001_0000, 32'h8000_0000);
    check("model_div0", {m.s, m.d0, m.ov}, {32'h7FFF_FFFF, 1'b1, 1'b0});
    m = model(32'h7FFF_0000, 32'h0000_8000);
    check("model_ovf", {m.s, m.d0, m.ov}, {32'h7FFF_FFFF, 1'b0, 1'b1});

    run_op("pos",      32'h0004_E000, 32'h0001_8000, 32'h0003_4000, 1'b0, 1'b0);
    run_op("neg",      32'h8004_E000, 32'h0001_8000, 32'h8003_4000, 1'b0, 1'b0);
    run_op("third",    32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0);
    run_op("div0",     32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_op("neg_zero", 32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0);
    run_op("ovf",      32'h7FFF_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 1'b1);

    // Abort mid-calculation with reset.
    A = 32'h0004_E000; B = 32'h0001_8000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("abort_outputs", {S, busy, done, div0, ovf}, 64'd0);
    rst = 1'b0;
    repeat (2) tick();
    run_op("after_abort", 32'h0002_0000, 32'h0001_0000, 32'h0002_0000, 1'b0, 1'b0);

    // start held high with inputs changing every cycle.
    prev = -1;
    start = 1'b1;
    for (int i = 0; i < 160; i++) begin
      A = $urandom;
      B = rand_b($urandom_range(0, 1));
      tick();
      if (done) begin
        if (prev >= 0) check("held_start_period", cycle - prev, 50);
        prev = cycle;
      end
    end
    start = 1'b0;
    repeat (LAT + 4) tick();

    // Random start pulses and operands, including starts during CALC and DONE.
    for (int i = 0; i < 3000; i++) begin
      mode  = $urandom_range(0, 3);
      start = ($urandom_range(0, 3) == 0);
      A     = (mode == 3) ? ($urandom & 32'h8000_FFFF) : $urandom;
      B     = rand_b(mode);
      tick();
    end
    start = 1'b0;
    repeat (LAT + 4) tick();
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cycle);
    $fatal(1, "timeout");
  end

endmodule
